fsub_seq: RTL and testbench

Multi-cycle IEEE-754 binary16 subtractor computing `a - b`. It is the effective-subtraction counterpart to the team's combinational FP16 adder. It uses bit-serial alignment and normalization to trade latency for area, and it has valid/ready handshakes on both sides. It sits in the FP datapath beside the adder and shares the same 16-bit operand format: sign[15], exponent[14:10] with bias 15, and mantissa[9:0].

---
 rtl/fsub_seq_if.sv | 22 ++
 rtl/fsub_seq.sv | 130 +++++++++++++
 tb/tb_fsub_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fsub_seq_if.sv
// fsub_seq_if: operand/result handshake bundle for fsub_seq; op exists only under FSUB_ADD_MODE_EN
interface fsub_seq_if #(parameter int BITS = 16);
    logic in_valid, in_ready, out_valid, out_ready, busy;
    logic [BITS-1:0] a, b, result;
`ifdef FSUB_ADD_MODE_EN
    logic op;
`endif
    modport master(
`ifdef FSUB_ADD_MODE_EN
        output op,
`endif
        output in_valid, a, b, out_ready,
        input in_ready, out_valid, result, busy
    );
    modport slave(
`ifdef FSUB_ADD_MODE_EN
        input op,
`endif
        input in_valid, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/fsub_seq.sv
// fsub_seq: multi-cycle binary16 a - b with bit-serial align/normalize; FSUB_ADD_MODE_EN adds op (1 = a + b)
module fsub_seq #(parameter int BITS = 16) (
    input logic clk,
    input logic rst,
    fsub_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
    state_t state;
    logic s, eff_add, zero, ov;
    logic [5:0] e;
    logic [13:0] mx, my;
    logic [14:0] m;
    logic [3:0] d;
    logic [BITS-1:0] res;
    logic add_op;
    logic [4:0] ea, eb, ex, ey, ediff;
    logic [9:0] fa, fb, fx, fy;
    logic sa, sb, a_big, nan_in, inf_a, inf_b, special, inc;
    logic [15:0] spec_res;
    logic [14:0] sum;
    logic [11:0] rnd;
    logic [5:0] e_rnd;
    logic [9:0] f_rnd;
`ifdef FSUB_ADD_MODE_EN
    assign add_op = bus.op;
`else
    assign add_op = 1'b0;
`endif
    assign bus.in_ready = (state == IDLE) && !rst;
    assign bus.busy = state != IDLE;
    assign bus.out_valid = ov;
    assign bus.result = res;
    always_comb begin
        ea = bus.a[14:10];
        eb = bus.b[14:10];
        fa = (ea == 5'd0) ? 10'd0 : bus.a[9:0];
        fb = (eb == 5'd0) ? 10'd0 : bus.b[9:0];
        sa = bus.a[15];
        sb = bus.b[15] ^ ~add_op;
        a_big = {ea, fa} >= {eb, fb};
        ex = a_big ? ea : eb;
        ey = a_big ? eb : ea;
        fx = a_big ? fa : fb;
        fy = a_big ? fb : fa;
        ediff = ex - ey;
        nan_in = (&ea & |bus.a[9:0]) | (&eb & |bus.b[9:0]);
        inf_a = &ea & ~|bus.a[9:0];
        inf_b = &eb & ~|bus.b[9:0];
        special = nan_in | inf_a | inf_b;
        spec_res = (nan_in | (inf_a & inf_b & (sa != sb))) ? 16'h7E00 :
                   inf_a ? {sa, 15'h7C00} : {sb, 15'h7C00};
        sum = eff_add ? {1'b0, mx} + {1'b0, my} : {1'b0, mx} - {1'b0, my};
        // m[13]=hidden, m[12:3]=fraction, m[2]=G, m[1]=R, m[0]=S
        inc = m[2] & (m[1] | m[0] | m[3]);
        rnd = {1'b0, m[13:3]} + {11'd0, inc};
        e_rnd = e + {5'd0, rnd[11]};
        f_rnd = rnd[11] ? rnd[10:1] : rnd[9:0];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ov <= 1'b0;
            res <= '0;
            s <= 1'b0;
            eff_add <= 1'b0;
            zero <= 1'b0;
            e <= '0;
            mx <= '0;
            my <= '0;
            m <= '0;
            d <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    if (special) begin
                        res <= spec_res;
                        ov <= 1'b1;
                        state <= DONE;
                    end else begin
                        s <= a_big ? sa : sb;
                        eff_add <= sa == sb;
                        zero <= 1'b0;
                        e <= {1'b0, ex};
                        mx <= {ex != 5'd0, fx, 3'b0};
                        my <= (ediff > 5'd13) ? {13'd0, ey != 5'd0} : {ey != 5'd0, fy, 3'b0};
                        d <= ediff[3:0];
                        state <= (ediff == 5'd0 || ediff > 5'd13) ? ADD : ALIGN;
                    end
                end
                ALIGN: begin
                    my <= {1'b0, my[13:2], my[1] | my[0]};
                    d <= d - 4'd1;
                    if (d == 4'd1) state <= ADD;
                end
                ADD: begin
                    m <= sum;
                    if (sum == 15'd0) begin
                        zero <= 1'b1;
                        s <= 1'b0;
                    end
                    state <= (sum != 15'd0 && (sum[14] || !sum[13])) ? NORM : ROUND;
                end
                NORM: begin
                    if (m[14]) begin
                        m <= {1'b0, m[14:2], m[1] | m[0]};
                        e <= e + 6'd1;
                        state <= ROUND;
                    end else if (e == 6'd1) begin
                        zero <= 1'b1;
                        state <= ROUND;
                    end else begin
                        m <= {m[13:0], 1'b0};
                        e <= e - 6'd1;
                        if (m[12]) state <= ROUND;
                    end
                end
                ROUND: begin
                    res <= zero ? {s, 15'd0} : (e_rnd >= 6'd31) ? {s, 15'h7C00} : {s, e_rnd[4:0], f_rnd};
                    ov <= 1'b1;
                    state <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    ov <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fsub_seq.sv
// tb_fsub_seq: directed vectors for fsub_seq checked against a real-arithmetic binary16 model
module tb_fsub_seq;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    fsub_seq_if #(.BITS(16)) bif();
    fsub_seq dut(.clk(clk), .rst(rst), .bus(bif));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    function automatic real pow2(input int n);
        real r = 1.0;
        for (int i = 0; i < (n < 0 ? -n : n); i++) r = (n < 0) ? r / 2.0 : r * 2.0;
        return r;
    endfunction

    function automatic real to_real(input logic [15:0] x);
        real v;
        if (x[14:10] == 5'd0) return 0.0;
        v = (1024.0 + real'(x[9:0])) * pow2(int'(x[14:10]) - 25);
        return x[15] ? -v : v;
    endfunction

    // exact difference in double precision, then round-to-nearest-even into binary16
    function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y);
        logic ys, sg;
        bit nx, ny, ix, iy;
        real dv, mv, q, rem;
        int ex, qi;
        ys = ~y[15];
        nx = (x[14:10] == 5'h1F) && (x[9:0] != 0);
        ny = (y[14:10] == 5'h1F) && (y[9:0] != 0);
        ix = (x[14:10] == 5'h1F) && (x[9:0] == 0);
        iy = (y[14:10] == 5'h1F) && (y[9:0] == 0);
        if (nx || ny) return 16'h7E00;
        if (ix && iy && (x[15] != ys)) return 16'h7E00;
        if (ix) return {x[15], 15'h7C00};
        if (iy) return {ys, 15'h7C00};
        dv = to_real(x) - to_real(y);
        if (dv == 0.0) return 16'h0000;
        sg = dv < 0.0;
        mv = sg ? -dv : dv;
        if (mv < pow2(-14)) return {sg, 15'h0000};
        ex = 0;
        while (mv >= 2.0) begin mv = mv / 2.0; ex++; end
        while (mv < 1.0) begin mv = mv * 2.0; ex--; end
        q = mv * 1024.0;
        qi = int'($floor(q));
        rem = q - real'(qi);
        if (rem > 0.5 || (rem == 0.5 && qi[0])) qi++;
        if (qi == 2048) begin qi = 1024; ex++; end
        if (ex > 15) return {sg, 15'h7C00};
        return {sg, 5'(ex + 15), 10'(qi)};
    endfunction

    // every cycle out_valid is high, result must equal the model's value for that transaction
    initial begin
        logic [15:0] cur;
        bit seen;
        seen = 0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (rst) seen = 0;
            else if (bif.out_valid) begin
                if (!seen) begin
                    seen = 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output @%0t: got %h expected no output", $time, bif.result);
                    end else cur = exp_q.pop_front();
                end
                chk("model_result", bif.result, cur);
            end else seen = 0;
        end
    end

    task automatic run(input logic [15:0] xa, input logic [15:0] xb, input int lat_exp,
                       input logic [15:0] hand, input int stall);
        int lat, wt;
        @(negedge clk);
        wt = 0;
        while (!bif.in_ready && wt < 50) begin @(negedge clk); wt++; end
        chk("in_ready_idle", bif.in_ready, 1);
        bif.a = xa;
        bif.b = xb;
        bif.in_valid = 1'b1;
        exp_q.push_back(model(xa, xb));
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
        lat = 1;
        while (!bif.out_valid && lat < 60) begin @(posedge clk); #1 lat++; end
        chk($sformatf("latency_%h_%h", xa, xb), lat, lat_exp);
        chk($sformatf("result_%h_%h", xa, xb), bif.result, hand);
        repeat (stall) begin
            @(negedge clk);
            chk("stall_in_ready", bif.in_ready, 0);
            chk("stall_out_valid", bif.out_valid, 1);
        end
        @(negedge clk);
        bif.out_ready = 1'b1;
        @(posedge clk);
        #1 bif.out_ready = 1'b0;
        chk("released_out_valid", bif.out_valid, 0);
        chk("released_in_ready", bif.in_ready, 1);
    endtask

    initial begin
        int hits;
        rst = 1'b1;
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b0;
        bif.a = '0;
        bif.b = '0;
`ifdef FSUB_ADD_MODE_EN
        bif.op = 1'b0;
`endif
        chk("model_pin_3m1", model(16'h4200, 16'h3C00), 16'h4000);
        chk("model_pin_tie", model(16'h4000, 16'h1000), 16'h4000);
        chk("model_pin_flush", model(16'h0400, 16'h0401), 16'h8000);
        #12;
        chk("rst_in_ready", bif.in_ready, 0);
        chk("rst_out_valid", bif.out_valid, 0);
        chk("rst_result", bif.result, 0);
        chk("rst_busy", bif.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_in_ready", bif.in_ready, 1);
        run(16'h4200, 16'h3C00, 4, 16'h4000, 5);
        run(16'h3C00, 16'h3C00, 3, 16'h0000, 0);
        run(16'h3C00, 16'hBC00, 4, 16'h4000, 0);
        run(16'h3C00, 16'h1000, 15, 16'h3BFF, 0);
        run(16'h7C00, 16'h7C00, 1, 16'h7E00, 0);
        run(16'h7BFF, 16'hFBFF, 4, 16'h7C00, 0);
        run(16'h7E00, 16'h3C00, 1, 16'h7E00, 0);
        run(16'h3C00, 16'h7C00, 1, 16'hFC00, 0);
        run(16'h0000, 16'h3C00, 3, 16'hBC00, 0);
        run(16'h0400, 16'h0401, 4, 16'h8000, 0);
        run(16'h4000, 16'h1000, 16, 16'h4000, 0);
        run(16'h3C00, 16'h0C00, 16, 16'h3C00, 0);
        run(16'h3C00, 16'h0800, 17, 16'h3C00, 0);
        run(16'h3C00, 16'h0400, 4, 16'h3C00, 0);
        run(16'h3C00, 16'hB800, 4, 16'h3E00, 0);
        run(16'h3C00, 16'h0200, 3, 16'h3C00, 0);
        // abort a long alignment with reset; nothing may come out of it
        @(negedge clk);
        bif.a = 16'h3C00;
        bif.b = 16'h1000;
        bif.in_valid = 1'b1;
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("align_busy", bif.busy, 1);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("abort_out_valid", bif.out_valid, 0);
        chk("abort_in_ready", bif.in_ready, 0);
        chk("abort_busy", bif.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("abort_reentry_in_ready", bif.in_ready, 1);
        hits = 0;
        repeat (20) begin @(negedge clk); if (bif.out_valid) hits++; end
        chk("abort_silent", hits, 0);
        run(16'h4200, 16'h3C00, 4, 16'h4000, 0);
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end
endmodule
